// File: rtl/lsram_fifo_pkg.sv
// Shared helpers for the LSRAM FIFO controller: log2 and parameter legality.
package lsram_fifo_pkg;

  localparam int PIPE_MAX = 1;

  function automatic int clog2(input int value);
    int v;
    int r;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit params_legal(input int depth, input int awidth,
                                      input int aempty_th, input int afull_th,
                                      input int pipe);
    return is_pow2(depth) && (depth >= 4) && (depth <= 4096) &&
           (awidth == clog2(depth)) && (aempty_th < afull_th) &&
           (afull_th <= depth) && (pipe >= 0) && (pipe <= PIPE_MAX);
  endfunction

endpackage

// File: rtl/lsram_fifo_ptr.sv
// Wrapping RAM address pointer; natural binary rollover from DEPTH-1 to 0.
module lsram_fifo_ptr
  import lsram_fifo_pkg::*;
#(
  parameter int AWIDTH = 7
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inc,
  output logic [AWIDTH-1:0] o_ptr
);

  logic [AWIDTH-1:0] r_ptr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/lsram_fifo_ctrl.sv
// Single-clock FIFO sequencer for a dual-port LSRAM: strobes, pointers,
// occupancy, status/error flags and read-data valid realignment.
module lsram_fifo_ctrl
  import lsram_fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 128,
  parameter int AWIDTH    = 7,
  parameter int PIPE      = 1,
  parameter int AFULL_TH  = 120,
  parameter int AEMPTY_TH = 8
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              WE,
  input  logic [WIDTH-1:0]  WDATA,
  input  logic              RE,
  input  logic              CLR_ERR,
  output logic [WIDTH-1:0]  RAM_WDATA,
  output logic [AWIDTH-1:0] RAM_WADDR,
  output logic              RAM_WEN,
  output logic [AWIDTH-1:0] RAM_RADDR,
  output logic              RAM_REN,
  input  logic [WIDTH-1:0]  RAM_RDATA,
  output logic [WIDTH-1:0]  DOUT,
  output logic              DVALID,
  output logic              FULL,
  output logic              EMPTY,
  output logic              AFULL,
  output logic              AEMPTY,
  output logic [AWIDTH:0]   COUNT,
  output logic              OVERFLOW,
  output logic              UNDERFLOW
);

  if (!params_legal(DEPTH, AWIDTH, AEMPTY_TH, AFULL_TH, PIPE)) begin : g_param_error
    $error("lsram_fifo_ctrl: illegal parameter combination");
  end

  localparam logic [AWIDTH:0] LP_DEPTH  = DEPTH[AWIDTH:0];
  localparam logic [AWIDTH:0] LP_AFULL  = AFULL_TH[AWIDTH:0];
  localparam logic [AWIDTH:0] LP_AEMPTY = AEMPTY_TH[AWIDTH:0];

  // Push/pop handshake: WE/RE are requests, registered FULL/EMPTY act as the
  // ready. A request is taken in the cycle it is high and its flag is clear;
  // a refused request is not retried and raises the sticky error flag.
  logic w_push_ok;
  logic w_pop_ok;
  logic [AWIDTH:0] w_count_nxt;

  logic [AWIDTH:0] r_count;
  logic            r_full;
  logic            r_empty;
  logic            r_afull;
  logic            r_aempty;
  logic            r_ovf;
  logic            r_udf;
  logic [PIPE:0]   r_vpipe;

  assign w_push_ok = WE & ~r_full;
  assign w_pop_ok  = RE & ~r_empty;

  lsram_fifo_ptr #(.AWIDTH(AWIDTH)) u_wr_ptr (
    .i_clk (CLOCK),
    .i_rst (RESET),
    .i_inc (w_push_ok),
    .o_ptr (RAM_WADDR)
  );

  lsram_fifo_ptr #(.AWIDTH(AWIDTH)) u_rd_ptr (
    .i_clk (CLOCK),
    .i_rst (RESET),
    .i_inc (w_pop_ok),
    .o_ptr (RAM_RADDR)
  );

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop_ok) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push_ok && w_pop_ok) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Flags are computed from the next occupancy so they settle with COUNT.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == LP_DEPTH);
      r_empty  <= (w_count_nxt == '0);
      r_afull  <= (w_count_nxt >= LP_AFULL);
      r_aempty <= (w_count_nxt <= LP_AEMPTY);
      r_ovf    <= (WE & r_full) | (r_ovf & ~CLR_ERR);
      r_udf    <= (RE & r_empty) | (r_udf & ~CLR_ERR);
    end
  end

  // Valid delay line matched to the RAM read latency (PIPE+1 cycles).
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_vpipe <= '0;
    end else begin
      r_vpipe[0] <= w_pop_ok;
      for (int i = 1; i <= PIPE; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
      end
    end
  end

  assign RAM_WDATA = WDATA;
  assign RAM_WEN   = w_push_ok;
  assign RAM_REN   = w_pop_ok;
  assign DOUT      = RAM_RDATA;
  assign DVALID    = r_vpipe[PIPE];
  assign FULL      = r_full;
  assign EMPTY     = r_empty;
  assign AFULL     = r_afull;
  assign AEMPTY    = r_aempty;
  assign COUNT     = r_count;
  assign OVERFLOW  = r_ovf;
  assign UNDERFLOW = r_udf;

endmodule
